// File: rtl/eth_phy_10g_pkg.sv
// Shared constants, FSM encoding and header helper for the 10G PHY RX block-lock logic.
package eth_phy_10g_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b10;
   localparam logic [1:0] SYNC_CTRL = 2'b01;

   localparam int LOCK_COUNT_DEF    = 64;
   localparam int INVALID_LIMIT_DEF = 16;
   localparam int BER_WINDOW        = 1024;
   localparam int BER_ERR_LIMIT     = 16;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      LOCKED = 2'd1,
      SLIP   = 2'd2
   } blk_state_e;

   function automatic logic hdr_is_valid(input logic [1:0] hdr);
      return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/eth_phy_10g_bitslip_pulse.sv
// High/low timed pulse generator: on start, pulse high HIGH_CYCLES, then blank LOW_CYCLES.
module eth_phy_10g_bitslip_pulse #(
   parameter int HIGH_CYCLES = 1,
   parameter int LOW_CYCLES  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   output logic busy_o,
   output logic pulse_o
);

   localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);

   if (HIGH_CYCLES < 1) begin : g_high_chk
      $error("eth_phy_10g_bitslip_pulse: HIGH_CYCLES must be >= 1");
   end
   if (LOW_CYCLES < 1) begin : g_low_chk
      $error("eth_phy_10g_bitslip_pulse: LOW_CYCLES must be >= 1");
   end

   logic [TW-1:0] timer_q, timer_d;
   logic          pulse_q, pulse_d;
   logic          low_q, low_d;

   always_comb begin
      pulse_d = pulse_q;
      low_d   = low_q;
      timer_d = timer_q;
      if (pulse_q) begin
         if (timer_q == '0) begin
            pulse_d = 1'b0;
            low_d   = 1'b1;
            timer_d = TW'(LOW_CYCLES - 1);
         end else begin
            timer_d = timer_q - 1'b1;
         end
      end else if (low_q) begin
         if (timer_q == '0) low_d = 1'b0;
         else               timer_d = timer_q - 1'b1;
      end else if (start_i) begin
         pulse_d = 1'b1;
         timer_d = TW'(HIGH_CYCLES - 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_q <= 1'b0;
         low_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         pulse_q <= pulse_d;
         low_q   <= low_d;
         timer_q <= timer_d;
      end
   end

   assign busy_o  = pulse_q | low_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/eth_phy_10g_rx_block_lock_ctrl.sv
// Block-lock FSM: slips the aligner until LOCK_COUNT good headers, drops lock on INVALID_LIMIT bad ones.
// Optional high-BER monitor enabled by `define ETH_PHY_10G_RX_HI_BER_EN.
module eth_phy_10g_rx_block_lock_ctrl
   import eth_phy_10g_pkg::*;
#(
   parameter int HDR_WIDTH           = 2,
   parameter int BITSLIP_HIGH_CYCLES = 1,
   parameter int BITSLIP_LOW_CYCLES  = 8,
   parameter int LOCK_COUNT          = LOCK_COUNT_DEF,
   parameter int INVALID_LIMIT       = INVALID_LIMIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
   input  logic                 serdes_rx_hdr_valid,
   output logic                 serdes_rx_bitslip,
   output logic                 rx_block_lock,
   output logic [7:0]           rx_slip_count,
   output logic                 rx_high_ber
);

   if (HDR_WIDTH != 2) begin : g_hdr_width_chk
      $error("eth_phy_10g_rx_block_lock_ctrl: only HDR_WIDTH == 2 is supported");
   end

   blk_state_e state_q, state_d;
   logic [6:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc;
   logic [4:0] sh_invld_cnt_q, sh_invld_cnt_d, invld_inc;
   logic [7:0] slip_cnt_q, slip_cnt_d;
   logic       slip_start_q, slip_start_d;
   logic       lock_q;
   logic       hdr_ok, go_slip, slip_busy, slip_pulse;

   assign hdr_ok     = hdr_is_valid(serdes_rx_hdr);
   assign sh_cnt_inc = sh_cnt_q + 7'd1;
   assign invld_inc  = sh_invld_cnt_q + {4'd0, ~hdr_ok};

   always_comb begin
      state_d        = state_q;
      sh_cnt_d       = sh_cnt_q;
      sh_invld_cnt_d = sh_invld_cnt_q;
      slip_cnt_d     = slip_cnt_q;
      slip_start_d   = 1'b0;
      go_slip        = 1'b0;
      case (state_q)
         SEARCH: if (serdes_rx_hdr_valid) begin
            if (!hdr_ok) begin
               go_slip = 1'b1;
            end else if (sh_cnt_q == 7'(LOCK_COUNT - 1)) begin
               sh_cnt_d       = '0;
               sh_invld_cnt_d = '0;
               state_d        = LOCKED;
            end else begin
               sh_cnt_d = sh_cnt_inc;
            end
         end
         LOCKED: if (serdes_rx_hdr_valid) begin
            // Loss of lock wins over a coincident window end.
            if (!hdr_ok && invld_inc == 5'(INVALID_LIMIT)) begin
               go_slip = 1'b1;
            end else if (sh_cnt_inc == 7'(LOCK_COUNT)) begin
               sh_cnt_d       = '0;
               sh_invld_cnt_d = '0;
            end else begin
               sh_cnt_d       = sh_cnt_inc;
               sh_invld_cnt_d = invld_inc;
            end
         end
         SLIP: if (!slip_busy && !slip_start_q) state_d = SEARCH;
         default: state_d = SEARCH;
      endcase
      if (go_slip) begin
         sh_cnt_d       = '0;
         sh_invld_cnt_d = '0;
         state_d        = SLIP;
         slip_start_d   = 1'b1;
         if (slip_cnt_q != 8'hFF) slip_cnt_d = slip_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= SEARCH;
         sh_cnt_q       <= '0;
         sh_invld_cnt_q <= '0;
         slip_cnt_q     <= '0;
         slip_start_q   <= 1'b0;
         lock_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         sh_cnt_q       <= sh_cnt_d;
         sh_invld_cnt_q <= sh_invld_cnt_d;
         slip_cnt_q     <= slip_cnt_d;
         slip_start_q   <= slip_start_d;
         lock_q         <= (state_d == LOCKED);
      end
   end

   // Start is registered so the pulse lands two cycles after the offending header.
   eth_phy_10g_bitslip_pulse #(
      .HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .LOW_CYCLES  (BITSLIP_LOW_CYCLES)
   ) u_slip (
      .clk     (clk),
      .rst     (rst),
      .start_i (slip_start_q),
      .busy_o  (slip_busy),
      .pulse_o (slip_pulse)
   );

   assign serdes_rx_bitslip = slip_pulse;
   assign rx_block_lock     = lock_q;
   assign rx_slip_count     = slip_cnt_q;

`ifdef ETH_PHY_10G_RX_HI_BER_EN
   logic [15:0] ber_win_q, ber_win_d;
   logic [4:0]  ber_err_q, ber_err_d, ber_err_inc;
   logic        ber_q, ber_d;

   assign ber_err_inc = (ber_err_q == 5'h1F) ? ber_err_q : ber_err_q + {4'd0, ~hdr_ok};

   always_comb begin
      ber_win_d = ber_win_q;
      ber_err_d = ber_err_q;
      ber_d     = ber_q;
      if (state_q != LOCKED || state_d != LOCKED) begin
         ber_win_d = '0;
         ber_err_d = '0;
         ber_d     = 1'b0;
      end else if (serdes_rx_hdr_valid) begin
         if (ber_win_q == 16'(BER_WINDOW - 1)) begin
            ber_d     = (ber_err_inc >= 5'(BER_ERR_LIMIT));
            ber_win_d = '0;
            ber_err_d = '0;
         end else begin
            ber_win_d = ber_win_q + 16'd1;
            ber_err_d = ber_err_inc;
            if (ber_err_inc >= 5'(BER_ERR_LIMIT)) ber_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ber_win_q <= '0;
         ber_err_q <= '0;
         ber_q     <= 1'b0;
      end else begin
         ber_win_q <= ber_win_d;
         ber_err_q <= ber_err_d;
         ber_q     <= ber_d;
      end
   end

   assign rx_high_ber = ber_q;
`else
   assign rx_high_ber = 1'b0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock_ctrl.sv
// Scoreboard bench for the RX block-lock controller: expected lock/slip edges and
// status snapshots are queued by the stimulus and checked by an independent monitor.
module tb_eth_phy_10g_rx_block_lock_ctrl;

   localparam int H0 = 1;
   localparam int L0 = 8;
   localparam int H1 = 4;
`ifdef ETH_PHY_10G_RX_HI_BER_EN
   localparam logic BER_EXP = 1'b1;
`else
   localparam logic BER_EXP = 1'b0;
`endif

   typedef enum logic [1:0] {EV_LOCK_RISE, EV_LOCK_FALL, EV_SLIP_RISE, EV_SLIP_FALL} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       cyc;
      int       cnt;
   } ev_t;
   typedef struct {
      bit         sel;
      int         cyc;
      logic       lock;
      logic       bs;
      logic [7:0] cnt;
      logic       ber;
      int         tag;
   } snap_t;

   logic       clk = 1'b0;
   logic       rst, rst1;
   logic [1:0] hdr, hdr1;
   logic       vld, vld1;
   logic       bs0, lock0, ber0, bs1, lock1, ber1;
   logic [7:0] cnt0, cnt1;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_errors = 0;
   int  exp_slips = 0;
   bit  mon_en = 1'b0;
   ev_t   ev_q[$];
   snap_t snap_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   eth_phy_10g_rx_block_lock_ctrl #(
      .HDR_WIDTH(2), .BITSLIP_HIGH_CYCLES(H0), .BITSLIP_LOW_CYCLES(L0),
      .LOCK_COUNT(64), .INVALID_LIMIT(16)
   ) u0 (
      .clk(clk), .rst(rst), .serdes_rx_hdr(hdr), .serdes_rx_hdr_valid(vld),
      .serdes_rx_bitslip(bs0), .rx_block_lock(lock0), .rx_slip_count(cnt0), .rx_high_ber(ber0)
   );

   eth_phy_10g_rx_block_lock_ctrl #(
      .HDR_WIDTH(2), .BITSLIP_HIGH_CYCLES(H1), .BITSLIP_LOW_CYCLES(8),
      .LOCK_COUNT(64), .INVALID_LIMIT(16)
   ) u1 (
      .clk(clk), .rst(rst1), .serdes_rx_hdr(hdr1), .serdes_rx_hdr_valid(vld1),
      .serdes_rx_bitslip(bs1), .rx_block_lock(lock1), .rx_slip_count(cnt1), .rx_high_ber(ber1)
   );

   function automatic int sat(input int n);
      return (n > 255) ? 255 : n;
   endfunction

   task automatic step(input logic [1:0] h, input logic v);
      hdr = h; vld = v;
      @(posedge clk); #1;
   endtask

   task automatic step1(input logic [1:0] h, input logic v);
      hdr1 = h; vld1 = v;
      @(posedge clk); #1;
   endtask

   task automatic push_ev(input ev_kind_e k, input int c, input int n);
      ev_t e;
      e.kind = k; e.cyc = c; e.cnt = n;
      ev_q.push_back(e);
   endtask

   task automatic push_snap(input bit sel, input int c, input logic l, input logic b,
                            input logic [7:0] n, input logic r, input int tag);
      snap_t s;
      s.sel = sel; s.cyc = c; s.lock = l; s.bs = b; s.cnt = n; s.ber = r; s.tag = tag;
      snap_q.push_back(s);
   endtask

   // Called right after the invalid header was sampled; covers the blanking interval.
   task automatic slip_blank(input bit lock_fall);
      exp_slips++;
      if (lock_fall) push_ev(EV_LOCK_FALL, cyc, sat(exp_slips));
      push_ev(EV_SLIP_RISE, cyc + 1, sat(exp_slips));
      push_ev(EV_SLIP_FALL, cyc + 1 + H0, sat(exp_slips));
      repeat (H0 + L0 + 1) step(2'b11, 1'b1);
      step(2'b00, 1'b0);
   endtask

   task automatic chk_ev(input ev_kind_e k);
      ev_t e;
      n_checks++;
      if (ev_q.size() == 0) begin
         n_errors++;
         $display("FAIL ev_unexpected: got %s @%0d cnt=%0d, expected no event",
                  k.name(), cyc, cnt0);
      end else begin
         e = ev_q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.cnt != int'(cnt0)) begin
            n_errors++;
            $display("FAIL ev: got %s @%0d cnt=%0d, expected %s @%0d cnt=%0d",
                     k.name(), cyc, cnt0, e.kind.name(), e.cyc, e.cnt);
         end
      end
   endtask

   // Monitor: snapshots on their target cycle, plus every lock/bitslip edge of u0.
   initial begin
      logic       pl, pb, al, ab, ar;
      logic [7:0] an;
      snap_t      s;
      pl = 1'b0; pb = 1'b0;
      forever begin
         @(negedge clk);
         while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            if (s.sel) begin al = lock1; ab = bs1; an = cnt1; ar = ber1; end
            else       begin al = lock0; ab = bs0; an = cnt0; ar = ber0; end
            n_checks++;
            if (s.cyc != cyc || al !== s.lock || ab !== s.bs || an !== s.cnt || ar !== s.ber) begin
               n_errors++;
               $display("FAIL snap%0d @%0d: got lock=%b slip=%b cnt=%0d ber=%b, expected lock=%b slip=%b cnt=%0d ber=%b @%0d",
                        s.tag, cyc, al, ab, an, ar, s.lock, s.bs, s.cnt, s.ber, s.cyc);
            end
         end
         if (mon_en) begin
            if (lock0 !== pl) chk_ev(lock0 ? EV_LOCK_RISE : EV_LOCK_FALL);
            if (bs0 !== pb)   chk_ev(bs0 ? EV_SLIP_RISE : EV_SLIP_FALL);
         end
         pl = lock0; pb = bs0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; rst1 = 1'b1;
      hdr = 2'b00; vld = 1'b0; hdr1 = 2'b00; vld1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      push_snap(0, cyc, 0, 0, 8'd0, 0, 1);
      push_snap(1, cyc, 0, 0, 8'd0, 0, 2);
      @(posedge clk); #1;
      rst = 1'b0; rst1 = 1'b0;
      mon_en = 1'b1;

      // A: 64 good headers lock with no slip
      repeat (63) step(2'b01, 1'b1);
      push_snap(0, cyc, 0, 0, 8'd0, 0, 3);
      step(2'b01, 1'b1);
      push_ev(EV_LOCK_RISE, cyc, 0);
      push_snap(0, cyc, 1, 0, 8'd0, 0, 4);

      // B: 15 bad in a window holds lock; 16 bad in the next window drops it
      repeat (15) step(2'b00, 1'b1);
      repeat (49) step(2'b10, 1'b1);
      push_snap(0, cyc, 1, 0, 8'd0, 0, 5);
      repeat (15) step(2'b10, 1'b1);
      repeat (15) step(2'b11, 1'b1);
      step(2'b00, 1'b1);
      slip_blank(1'b1);
      push_snap(0, cyc, 0, 0, 8'd1, 0, 6);

      // C: misaligned stream, three more slips, then lock
      repeat (3) step(2'b01, 1'b1);
      step(2'b00, 1'b1);
      slip_blank(1'b0);
      repeat (2) step(2'b10, 1'b1);
      step(2'b11, 1'b1);
      slip_blank(1'b0);
      step(2'b00, 1'b1);
      slip_blank(1'b0);
      for (int i = 0; i < 64; i++) step((i % 2) ? 2'b01 : 2'b10, 1'b1);
      push_ev(EV_LOCK_RISE, cyc, 4);

      // D: 16th bad header coincides with window end; loss wins
      repeat (48) step(2'b10, 1'b1);
      repeat (15) step(2'b00, 1'b1);
      step(2'b11, 1'b1);
      slip_blank(1'b1);
      // hdr_valid toggling: lock after 64 qualified headers
      for (int i = 0; i < 64; i++) begin
         step(2'b01, 1'b1);
         if (i != 63) step(2'b11, 1'b0);
      end
      push_ev(EV_LOCK_RISE, cyc, 5);

      // F: 16 bad headers spread over a 1024-header window
      for (int i = 0; i < 1024; i++) begin
         step((i % 64 == 0) ? 2'b00 : 2'b01, 1'b1);
         if (i == 959) push_snap(0, cyc, 1, 0, 8'd5, 0, 7);
      end
      push_snap(0, cyc, 1, 0, 8'd5, BER_EXP, 8);

      // E: lose lock, then drive the slip counter into saturation
      repeat (15) step(2'b00, 1'b1);
      step(2'b11, 1'b1);
      slip_blank(1'b1);
      push_snap(0, cyc, 0, 0, 8'd6, 0, 9);
      while (exp_slips < 258) begin
         step(2'b00, 1'b1);
         slip_blank(1'b0);
      end
      push_snap(0, cyc, 0, 0, 8'd255, 0, 10);

      // u1 (HIGH=4): async reset in the middle of a slip pulse
      hdr = 2'b00; vld = 1'b0;
      step1(2'b00, 1'b1);
      vld1 = 1'b0;
      push_snap(1, cyc, 0, 0, 8'd1, 0, 11);
      @(posedge clk); #1;
      push_snap(1, cyc, 0, 1, 8'd1, 0, 12);
      @(posedge clk); #2;
      rst1 = 1'b1;
      push_snap(1, cyc, 0, 0, 8'd0, 0, 13);
      @(posedge clk); #1;
      rst1 = 1'b0;
      repeat (63) step1(2'b10, 1'b1);
      push_snap(1, cyc, 0, 0, 8'd0, 0, 14);
      step1(2'b01, 1'b1);
      push_snap(1, cyc, 1, 0, 8'd0, 0, 15);

      repeat (20) step(2'b00, 1'b0);
      n_checks++;
      if (ev_q.size() != 0 || snap_q.size() != 0) begin
         n_errors++;
         $display("FAIL queues_drained: got %0d events and %0d snapshots pending, expected 0 and 0",
                  ev_q.size(), snap_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
